// File: rtl/nv_nvdla_mac2accu_align.sv
// Pairs the MAC a/b half-result streams in order and drives one retimed a+b stream to the accumulator.
// Latency: accu_pvld rises 1+RT_STAGES cycles after the later beat of a pair is pushed; 1 pair/cycle sustained.
// No backpressure: inputs are valid-only; a push into a full side with no pop that cycle is dropped and flagged.
module nv_nvdla_mac2accu_align #(
  parameter int NUM_CH    = 8,
  parameter int DW        = 176,
  parameter int PDW       = 9,
  parameter int DEPTH     = 4,
  parameter int RT_STAGES = 1
) (
  input  logic                      nvdla_core_clk,
  input  logic                      nvdla_core_rst,
  input  logic                      flush,
  input  logic                      err_clr,
  input  logic                      mac_a_pvld,
  input  logic [7:0]                mac_a_mask,
  input  logic [7:0]                mac_a_mode,
  input  logic [NUM_CH*DW-1:0]      mac_a_data,
  input  logic [PDW-1:0]            mac_a_pd,
  input  logic                      mac_b_pvld,
  input  logic [7:0]                mac_b_mask,
  input  logic [7:0]                mac_b_mode,
  input  logic [NUM_CH*DW-1:0]      mac_b_data,
  input  logic [PDW-1:0]            mac_b_pd,
  output logic                      accu_pvld,
  output logic [7:0]                accu_a_mask,
  output logic [7:0]                accu_a_mode,
  output logic [NUM_CH*DW-1:0]      accu_a_data,
  output logic [PDW-1:0]            accu_a_pd,
  output logic [7:0]                accu_b_mask,
  output logic [7:0]                accu_b_mode,
  output logic [NUM_CH*DW-1:0]      accu_b_data,
  output logic [PDW-1:0]            accu_b_pd,
  output logic [$clog2(DEPTH):0]    occ_a,
  output logic [$clog2(DEPTH):0]    occ_b,
  output logic                      ovf_a,
  output logic                      ovf_b,
  output logic                      pd_mismatch,
  output logic [7:0]                mismatch_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef struct packed {
    logic [7:0]           mask;
    logic [7:0]           mode;
    logic [PDW-1:0]       pd;
    logic [NUM_CH*DW-1:0] data;
  } ent_t;

  typedef struct packed {
    ent_t a;
    ent_t b;
  } pair_t;

  // Index 0 is side a, index 1 is side b throughout.
  logic [1:0]         side_vld;
  ent_t [1:0]         side_ent;
  ent_t [1:0]         head;
  logic [1:0][OW-1:0] occ;
  logic [1:0]         push;
  logic [1:0]         ovf_ev;
  logic               pop;
  logic               mm_ev;

  assign side_vld    = {mac_b_pvld, mac_a_pvld};
  assign side_ent[0] = {mac_a_mask, mac_a_mode, mac_a_pd, mac_a_data};
  assign side_ent[1] = {mac_b_mask, mac_b_mode, mac_b_pd, mac_b_data};

  // Pairing looks only at registered occupancy, so a beat is never paired in its push cycle.
  assign pop   = !flush && (occ[0] != '0) && (occ[1] != '0);
  assign mm_ev = pop && (head[0].pd != head[1].pd);

  for (genvar s = 0; s < 2; s++) begin : g_side
    ent_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ_q;
    logic          full;

    // A full side still accepts a beat when its head leaves in the same cycle.
    assign full      = (occ_q == OW'(DEPTH));
    assign push[s]   = !flush && side_vld[s] && (!full || pop);
    assign ovf_ev[s] = !flush && side_vld[s] && full && !pop;
    assign occ[s]    = occ_q;
    assign head[s]   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; occupancy disambiguates full from empty.
    always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst || flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ_q  <= '0;
      end else begin
        if (push[s]) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        occ_q <= occ_q + OW'(push[s]) - OW'(pop);
      end
    end

    // Entry storage; contents are don't-care until a pointer reaches them.
    always_ff @(posedge nvdla_core_clk) begin
      if (!nvdla_core_rst && push[s]) mem[wr_ptr] <= side_ent[s];
    end
  end

  logic [1:0] ovf_q;

  // Sticky error flags and saturating mismatch counter; a same-cycle event beats err_clr.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      ovf_q        <= '0;
      pd_mismatch  <= 1'b0;
      mismatch_cnt <= '0;
    end else if (err_clr) begin
      ovf_q        <= ovf_ev;
      pd_mismatch  <= mm_ev;
      mismatch_cnt <= mm_ev ? 8'd1 : 8'd0;
    end else begin
      ovf_q       <= ovf_q | ovf_ev;
      pd_mismatch <= pd_mismatch | mm_ev;
      if (mm_ev && (mismatch_cnt != 8'hff)) mismatch_cnt <= mismatch_cnt + 8'd1;
    end
  end

  assign ovf_a = ovf_q[0];
  assign ovf_b = ovf_q[1];
  assign occ_a = occ[0];
  assign occ_b = occ[1];

  pair_t [RT_STAGES-1:0] st_dat;
  logic  [RT_STAGES-1:0] st_vld;

  // Retiming chain: valids always shift, data only moves behind a valid so idle stages hold.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      st_vld <= '0;
      st_dat <= '0;
    end else begin
      st_vld[0] <= pop;
      if (pop) st_dat[0] <= {head[0], head[1]};
      for (int i = 1; i < RT_STAGES; i++) begin
        st_vld[i] <= st_vld[i-1];
        if (st_vld[i-1]) st_dat[i] <= st_dat[i-1];
      end
      if (flush) st_vld <= '0;
    end
  end

  pair_t out;
  assign out         = st_dat[RT_STAGES-1];
  assign accu_pvld   = st_vld[RT_STAGES-1];
  assign accu_a_mask = out.a.mask;
  assign accu_a_mode = out.a.mode;
  assign accu_a_data = out.a.data;
  assign accu_a_pd   = out.a.pd;
  assign accu_b_mask = out.b.mask;
  assign accu_b_mode = out.b.mode;
  assign accu_b_data = out.b.data;
  assign accu_b_pd   = out.b.pd;

endmodule

// File: tb/tb_nv_nvdla_mac2accu_align.sv
// Bench for nv_nvdla_mac2accu_align: two instances (RT_STAGES 1 and 3) share one stimulus stream.
// Reference model keeps per-side queues and a schedule of when each popped pair must appear.
// Directed phases (aligned, skew, saturation, flush, reset) followed by a randomized phase.
module tb_nv_nvdla_mac2accu_align;
  localparam int NUM_CH = 2;
  localparam int DW     = 16;
  localparam int PDW    = 9;
  localparam int DEPTH  = 4;
  localparam int DATW   = NUM_CH * DW;
  localparam int OW     = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [7:0]      mask;
    logic [7:0]      mode;
    logic [PDW-1:0]  pd;
    logic [DATW-1:0] data;
  } ent_t;

  typedef struct {
    int   due;
    ent_t a;
    ent_t b;
  } pend_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, flush, err_clr;
  logic            a_vld, b_vld;
  logic [7:0]      a_mask, a_mode, b_mask, b_mode;
  logic [DATW-1:0] a_data, b_data;
  logic [PDW-1:0]  a_pd, b_pd;

  logic            pv   [2];
  logic [7:0]      am   [2];
  logic [7:0]      amd  [2];
  logic [DATW-1:0] ad   [2];
  logic [PDW-1:0]  ap   [2];
  logic [7:0]      bm   [2];
  logic [7:0]      bmd  [2];
  logic [DATW-1:0] bd   [2];
  logic [PDW-1:0]  bp   [2];
  logic [OW-1:0]   occa [2];
  logic [OW-1:0]   occb [2];
  logic            ova  [2];
  logic            ovb  [2];
  logic            mm   [2];
  logic [7:0]      cnt  [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    nv_nvdla_mac2accu_align #(
      .NUM_CH(NUM_CH), .DW(DW), .PDW(PDW), .DEPTH(DEPTH), .RT_STAGES(g == 0 ? 1 : 3)
    ) u_dut (
      .nvdla_core_clk(clk),
      .nvdla_core_rst(rst),
      .flush(flush),
      .err_clr(err_clr),
      .mac_a_pvld(a_vld),
      .mac_a_mask(a_mask),
      .mac_a_mode(a_mode),
      .mac_a_data(a_data),
      .mac_a_pd(a_pd),
      .mac_b_pvld(b_vld),
      .mac_b_mask(b_mask),
      .mac_b_mode(b_mode),
      .mac_b_data(b_data),
      .mac_b_pd(b_pd),
      .accu_pvld(pv[g]),
      .accu_a_mask(am[g]),
      .accu_a_mode(amd[g]),
      .accu_a_data(ad[g]),
      .accu_a_pd(ap[g]),
      .accu_b_mask(bm[g]),
      .accu_b_mode(bmd[g]),
      .accu_b_data(bd[g]),
      .accu_b_pd(bp[g]),
      .occ_a(occa[g]),
      .occ_b(occb[g]),
      .ovf_a(ova[g]),
      .ovf_b(ovb[g]),
      .pd_mismatch(mm[g]),
      .mismatch_cnt(cnt[g])
    );
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  ent_t  qa[$];
  ent_t  qb[$];
  pend_t pend0[$];
  pend_t pend1[$];
  bit    m_ova, m_ovb, m_mm;
  int    m_cnt;
  int    edge_no;
  bit    just_reset;

  // Advance the model by one clock edge using the inputs as driven before the edge.
  task automatic model_edge();
    int   sa, sb;
    bit   pop, ev_mm, ev_oa, ev_ob;
    ent_t ha, hb;
    pend_t p;
    just_reset = 0;
    if (rst) begin
      qa.delete(); qb.delete(); pend0.delete(); pend1.delete();
      m_ova = 0; m_ovb = 0; m_mm = 0; m_cnt = 0;
      just_reset = 1;
      return;
    end
    sa = qa.size();
    sb = qb.size();
    pop = !flush && sa > 0 && sb > 0;
    ev_mm = 0;
    if (pop) ev_mm = (qa[0].pd != qb[0].pd);
    ev_oa = !flush && a_vld && sa == DEPTH && !pop;
    ev_ob = !flush && b_vld && sb == DEPTH && !pop;
    if (flush) begin
      qa.delete(); qb.delete(); pend0.delete(); pend1.delete();
    end else begin
      if (pop) begin
        ha = qa.pop_front();
        hb = qb.pop_front();
        p.a = ha; p.b = hb;
        p.due = edge_no;     pend0.push_back(p);
        p.due = edge_no + 2; pend1.push_back(p);
      end
      if (a_vld && (sa < DEPTH || pop)) qa.push_back({a_mask, a_mode, a_pd, a_data});
      if (b_vld && (sb < DEPTH || pop)) qb.push_back({b_mask, b_mode, b_pd, b_data});
    end
    if (err_clr) begin
      m_ova = ev_oa; m_ovb = ev_ob; m_mm = ev_mm; m_cnt = ev_mm ? 1 : 0;
    end else begin
      m_ova |= ev_oa; m_ovb |= ev_ob; m_mm |= ev_mm;
      if (ev_mm && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic check_inst(input int g);
    pend_t p;
    bit    ev;
    ev = 0;
    if (g == 0) begin
      if (pend0.size() > 0 && pend0[0].due == edge_no) begin ev = 1; p = pend0.pop_front(); end
    end else begin
      if (pend1.size() > 0 && pend1[0].due == edge_no) begin ev = 1; p = pend1.pop_front(); end
    end
    check($sformatf("pvld%0d@%0d", g, edge_no), 64'(pv[g]), 64'(ev));
    if (ev) begin
      check($sformatf("pair_a%0d@%0d", g, edge_no), 64'({am[g], amd[g], ap[g], ad[g]}), 64'(p.a));
      check($sformatf("pair_b%0d@%0d", g, edge_no), 64'({bm[g], bmd[g], bp[g], bd[g]}), 64'(p.b));
    end
    if (just_reset) begin
      check($sformatf("rst_a%0d", g), 64'({am[g], amd[g], ap[g], ad[g]}), 64'd0);
      check($sformatf("rst_b%0d", g), 64'({bm[g], bmd[g], bp[g], bd[g]}), 64'd0);
    end
    check($sformatf("occ_a%0d@%0d", g, edge_no), 64'(occa[g]), 64'(qa.size()));
    check($sformatf("occ_b%0d@%0d", g, edge_no), 64'(occb[g]), 64'(qb.size()));
    check($sformatf("ovf_a%0d@%0d", g, edge_no), 64'(ova[g]), 64'(m_ova));
    check($sformatf("ovf_b%0d@%0d", g, edge_no), 64'(ovb[g]), 64'(m_ovb));
    check($sformatf("pd_mm%0d@%0d", g, edge_no), 64'(mm[g]), 64'(m_mm));
    check($sformatf("mm_cnt%0d@%0d", g, edge_no), 64'(cnt[g]), 64'(m_cnt));
  endtask

  // One clock: edge, model update, check 1ns later, then return controls to idle.
  task automatic tick();
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
    check_inst(0);
    check_inst(1);
    rst = 0; flush = 0; err_clr = 0; a_vld = 0; b_vld = 0;
  endtask

  task automatic set_a(input bit v, input int pd);
    a_vld = v; a_pd = PDW'(pd);
    a_mask = 8'($urandom); a_mode = 8'($urandom); a_data = DATW'($urandom);
  endtask

  task automatic set_b(input bit v, input int pd);
    b_vld = v; b_pd = PDW'(pd);
    b_mask = 8'($urandom); b_mode = 8'($urandom); b_data = DATW'($urandom);
  endtask

  initial begin
    edge_no = 0;
    rst = 1; flush = 0; err_clr = 0;
    set_a(0, 0); set_b(0, 0);
    m_ova = 0; m_ovb = 0; m_mm = 0; m_cnt = 0; just_reset = 0;
    tick();
    rst = 1; tick();

    // Aligned stream
    for (int i = 0; i < 10; i++) begin set_a(1, i); set_b(1, i); tick(); end
    repeat (5) tick();

    // Skewed streams: b lags a by 3, 4 and 5 beats
    for (int sk = 3; sk <= 5; sk++) begin
      for (int t = 0; t < 20 + sk; t++) begin
        if (t < 20) set_a(1, t);
        if (t >= sk) set_b(1, t - sk);
        tick();
      end
      repeat (6) tick();
      flush = 1; tick();
      tick();
    end

    // Mismatch saturation and err_clr behaviour
    for (int i = 0; i < 300; i++) begin set_a(1, 1); set_b(1, 2); tick(); end
    repeat (5) tick();
    err_clr = 1; tick();
    tick();
    set_a(1, 1); set_b(1, 2); tick();
    err_clr = 1; tick();
    repeat (4) tick();

    // Flush mid-stream with a pair in flight and side a partially filled
    set_a(1, 7); set_b(1, 7); tick();
    set_a(1, 8); tick();
    set_a(1, 9); tick();
    set_a(1, 10); tick();
    flush = 1; set_a(1, 11); set_b(1, 11); tick();
    set_a(1, 12); set_b(1, 12); tick();
    repeat (5) tick();

    // Randomized traffic with occasional flush, err_clr and reset
    for (int i = 0; i < 800; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      flush   = ($urandom_range(0, 59) == 0);
      err_clr = ($urandom_range(0, 39) == 0);
      set_a($urandom_range(0, 2) != 0, int'($urandom_range(0, 3)));
      set_b($urandom_range(0, 2) != 0, int'($urandom_range(0, 3)));
      tick();
    end
    repeat (6) tick();

    // Reset with a full retiming pipeline
    for (int i = 0; i < 6; i++) begin set_a(1, 20 + i); set_b(1, 20 + i); tick(); end
    rst = 1; set_a(1, 30); set_b(1, 30); tick();
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
